// File: rtl/sync_fifo_cnt.sv
// sync_fifo_cnt
//   Single-clock FIFO between the write-control FSM and the downstream
//   reader. Exports a registered occupancy count for the FSM's stop/restart
//   hysteresis, full/empty flags decoded from that count, a registered read
//   port and sticky overflow/underflow debug flags.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   wr_en      write request (ignored while full)
//   wr_data    write data, captured when the write is accepted
//   rd_en      read request (ignored while empty)
//   rd_data    registered read data, holds its value between reads
//   rd_valid   one-cycle pulse, rd_data carries a newly read word
//   words      occupancy 0..DEPTH
//   full       words == DEPTH
//   empty      words == 0
//   overflow   sticky, set by a write request while full
//   underflow  sticky, set by a read request while empty
//   err_clr    synchronous clear of overflow/underflow (a new error wins)
module sync_fifo_cnt #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  output logic [COUNT_WIDTH-1:0] words,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   err_clr
);

  localparam logic [COUNT_WIDTH-1:0] DEPTH_CNT = COUNT_WIDTH'(DEPTH);

  // Storage is deliberately left out of reset so it maps onto block RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [COUNT_WIDTH-1:0] words_reg, words_next;
  logic [DATA_WIDTH-1:0]  rd_data_reg;
  logic                   rd_valid_reg;
  logic                   overflow_reg, overflow_next;
  logic                   underflow_reg, underflow_next;

  logic full_int;
  logic empty_int;
  logic wr_acc;
  logic rd_acc;

  // Flags come straight from the registered count, so they only move on
  // clock edges and never see a combinational path from the requests.
  assign full_int  = (words_reg == DEPTH_CNT);
  assign empty_int = (words_reg == '0);

  // A read that frees a slot does not let a same-cycle write in while full,
  // and there is no write-to-read bypass while empty.
  assign wr_acc = wr_en & ~full_int;
  assign rd_acc = rd_en & ~empty_int;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    words_next     = words_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    // Pointers are exactly ADDR_WIDTH bits, so +1 wraps mod DEPTH.
    if (wr_acc) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (rd_acc) rd_ptr_next = rd_ptr_reg + 1'b1;

    case ({wr_acc, rd_acc})
      2'b10:   words_next = words_reg + 1'b1;
      2'b01:   words_next = words_reg - 1'b1;
      default: words_next = words_reg;
    endcase

    // Clear first, then set, so an error in the clearing cycle survives.
    if (err_clr) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (wr_en & full_int)  overflow_next  = 1'b1;
    if (rd_en & empty_int) underflow_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      words_reg     <= '0;
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      words_reg     <= words_next;
      rd_valid_reg  <= rd_acc;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      if (rd_acc) rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_data   = rd_data_reg;
  assign rd_valid  = rd_valid_reg;
  assign words     = words_reg;
  assign full      = full_int;
  assign empty     = empty_int;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule
